uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer that sits directly downstream of the UART receiver inside uarttxrx.
- Captures each byte the receiver completes, on its one-cycle done strobe, and holds it in a circular FIFO until the host logic reads it.
- Decouples the bursty serial receive rate from the consumer and flags lost bytes with a sticky overrun bit.

Parameters:
- DATA_W, 8, width of one received character.
- ADDR_W, 4, pointer width; depth = 2**ADDR_W = 16 entries.

Ports:
- clk1  in  1  system clock; all logic on rising edge.
- ret1  in  1  asynchronous, active-high reset.
- rx_done  in  1  one-cycle strobe from the receiver; rx_data is valid in that cycle.
- rx_data  in  DATA_W  received byte.
- rd  in  1  read request from the consumer.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data holds a new byte.
- empty  out  1  high when count == 0.
- full  out  1  high when count == 2**ADDR_W.
- count  out  ADDR_W+1  number of stored bytes, 0..16.
- overrun  out  1  sticky; a byte was dropped.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (ret1=1, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - rd_data = 0, rd_valid = 0, overrun = 0.
  - empty = 1, full = 0.
  - Memory array is not reset.
  - Reset mid-operation discards all stored bytes immediately; the first rx_done after deassertion writes to entry 0.
- Write accept: rx_done & (!full | rd_acc).
  - Stores rx_data at mem[wr_ptr].
  - wr_ptr increments modulo 2**ADDR_W; natural wrap from 15 to 0.
- Read accept (rd_acc): rd & !empty.
  - Next edge: rd_data = mem[rd_ptr], rd_valid = 1, rd_ptr increments modulo depth.
  - Latency is 1 cycle from rd sampled high to rd_valid.
  - rd while empty is ignored: rd_valid = 0, rd_data holds its previous value.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
  - empty and full are decoded from count (combinational from registered count).
- Simultaneous events:
  - Full with rx_done and rd in the same cycle: the read frees a slot, the write is accepted, count stays 16, no overrun.
  - Empty with rx_done and rd in the same cycle: only the write happens; the read is ignored; count becomes 1. Write data is never bypassed to rd_data.
- Overflow: rx_done while full with no read accepted.
  - The byte is dropped; pointers and count are unchanged; overrun is set.
- overrun:
  - Set has priority over ovr_clr in the same cycle.
  - Otherwise ovr_clr clears it on the next edge.
  - It is never cleared by reads.
- rd_valid is high for exactly one cycle per accepted read; back-to-back rd gives one byte per cycle.
- Byte order is strictly first-in, first-out across pointer wrap.
- Storage is one register array written on clk1; no clock-enable or reset on data bits is required.

Test Plan:
- Reset, then rx_done with rx_data=8'h75 for one cycle, then rd one cycle later:
  - count goes 0→1→0.
  - rd_valid pulses one cycle after rd with rd_data=8'h75.
  - empty returns to 1.
- Write 16 bytes 8'h00..8'h0F, then a 17th byte 8'hAA:
  - full=1, count=16, overrun=1.
  - Draining 16 reads yields 8'h00..8'h0F in order; 8'hAA is never seen.
- Fill to 16, then assert rx_done=8'h55 and rd together:
  - rd_data=8'h00, count stays 16, overrun stays 0.
  - After draining, the last byte read is 8'h55.
- Wrap-around: write/read 40 bytes (8'h01..8'h28) interleaved with count never exceeding 5:
  - Every byte is returned in order.
  - Pointers wrap twice with no loss.
- rd while empty, and rd+rx_done=8'h33 on empty:
  - First case: no rd_valid and rd_data unchanged.
  - Second case: count=1 and no rd_valid.
  - A later rd returns 8'h33.
- Load 3 bytes, assert ret1 mid-stream for 1 cycle (asynchronously, between edges):
  - count=0, empty=1, overrun=0, rd_data=0 immediately.
  - Overrun set followed by ovr_clr coinciding with another overflow keeps overrun=1.
  - ovr_clr alone clears it.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// Captures each completed byte on the rx_done strobe and buffers it for the
// host. Bytes that arrive while the FIFO is full are dropped and reported
// through the sticky overrun flag.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk1,
  input  logic              ret1,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int unsigned   DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // Status flags are decoded from the registered count.
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A read frees a slot, so a write is still accepted when full if a read
  // is accepted in the same cycle. Writes are never bypassed to rd_data.
  assign rd_acc = rd & ~empty;
  assign wr_acc = rx_done & (~full | rd_acc);

  // Data storage; no reset on the array.
  always_ff @(posedge clk1) begin
    if (wr_acc) mem[wr_ptr] <= rx_data;
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk1 or posedge ret1) begin
    if (ret1) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun: a dropped byte wins over a same-cycle clear.
  always_ff @(posedge clk1 or posedge ret1) begin
    if (ret1) begin
      overrun <= 1'b0;
    end else if (rx_done && !wr_acc) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
